// File: rtl/soma_pkg.sv
// Shared widths and state encoding for the sequential four-operand adder.
package soma_pkg;

    localparam int W_AB  = 4;
    localparam int W_CD  = 3;
    localparam int W_ACC = 6;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUM  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The spare code 2'd3 is never entered and decodes back to IDLE.
    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_SUM  = SUM,
        S_DONE = DONE,
        S_RSVD = 2'd3
    } state_t;

endpackage

// File: rtl/soma_seq_ctrl_somador_6b.sv
// Combinational 6-bit unsigned adder; the carry out is not needed because sums never exceed 44.
module somador_6b
    import soma_pkg::*;
(
    input  logic [W_ACC-1:0] a,
    input  logic [W_ACC-1:0] b,
    output logic [W_ACC-1:0] s
);

    assign s = a + b;

endmodule

// File: rtl/soma_seq_ctrl.sv
// Sequential controller: captures four operands and sums them one per cycle through one shared adder.
module soma_seq_ctrl
    import soma_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W_AB-1:0] A,
    input  logic [W_AB-1:0] B,
    input  logic [W_CD-1:0] C,
    input  logic [W_CD-1:0] D,
    output logic            busy,
    output logic            done,
    output logic [5:0]      S6,
    output logic [4:0]      S5,
    output logic [3:0]      S4,
    output logic [2:0]      S3,
    output logic            ovf5,
    output logic            ovf4,
    output logic            ovf3
);

    state_t           state_reg, state_next;
    logic [W_ACC-1:0] acc_reg, acc_next;
    logic [1:0]       step_reg, step_next;
    logic [W_ACC-1:0] op_reg  [4];
    logic [W_ACC-1:0] op_next [4];
    logic [W_ACC-1:0] s6_reg, s6_next;
    logic [W_ACC-1:0] add_sum;
    logic             capture;

    somador_6b u_add (
        .a (acc_reg),
        .b (op_reg[step_reg]),
        .s (add_sum)
    );

    assign capture = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        step_next  = step_reg;
        s6_next    = s6_reg;
        for (int i = 0; i < 4; i++) op_next[i] = op_reg[i];

        unique case (state_reg)
            S_IDLE, S_DONE: begin
                if (capture) begin
                    op_next[0] = {{(W_ACC-W_AB){1'b0}}, A};
                    op_next[1] = {{(W_ACC-W_AB){1'b0}}, B};
                    op_next[2] = {{(W_ACC-W_CD){1'b0}}, C};
                    op_next[3] = {{(W_ACC-W_CD){1'b0}}, D};
                    acc_next   = '0;
                    step_next  = 2'd0;
                    state_next = S_SUM;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_SUM: begin
                acc_next  = add_sum;
                step_next = step_reg + 2'd1;
                if (step_reg == 2'd3) begin
                    s6_next    = add_sum;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            acc_reg   <= '0;
            step_reg  <= 2'd0;
            s6_reg    <= '0;
            for (int i = 0; i < 4; i++) op_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            step_reg  <= step_next;
            s6_reg    <= s6_next;
            for (int i = 0; i < 4; i++) op_reg[i] <= op_next[i];
        end
    end

    // Status decodes straight from the state so reset clears it without waiting for an edge.
    assign busy = (state_reg == S_SUM);
    assign done = (state_reg == S_DONE);

    assign S6   = s6_reg;
    assign S5   = s6_reg[4:0];
    assign S4   = s6_reg[3:0];
    assign S3   = s6_reg[2:0];
    assign ovf5 = s6_reg[5];
    assign ovf4 = |s6_reg[5:4];
    assign ovf3 = |s6_reg[5:3];

endmodule

// File: tb/tb_soma_seq_ctrl.sv
// Bench for soma_seq_ctrl: spec vectors, multi-cycle corner sequences and random traffic vs a timing model.
module tb_soma_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A = '0, B = '0;
    logic [2:0] C = '0, D = '0;
    logic       busy, done, ovf5, ovf4, ovf3;
    logic [5:0] S6;
    logic [4:0] S5;
    logic [3:0] S4;
    logic [2:0] S3;

    int errors = 0;
    int checks = 0;

    soma_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A(A), .B(B), .C(C), .D(D),
        .busy(busy), .done(done),
        .S6(S6), .S5(S5), .S4(S4), .S3(S3),
        .ovf5(ovf5), .ovf4(ovf4), .ovf3(ovf3)
    );

    always #5 clk = ~clk;

    // Reference model: m_cnt is cycles since capture (-1 = nothing in flight, 4 = result cycle).
    int m_cnt = -1;
    int m_pend = 0;
    int m_res = 0;

    task automatic model_reset();
        m_cnt = -1; m_pend = 0; m_res = 0;
    endtask

    task automatic model_step(input logic st, input int a, b, c, d);
        if (m_cnt == -1 || m_cnt == 4) begin
            if (st) begin
                m_cnt  = 0;
                m_pend = a + b + c + d;
            end else begin
                m_cnt = -1;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 4) m_res = m_pend;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int dut_vec();
        return {busy, done, S6, S5, S4, S3, ovf5, ovf4, ovf3};
    endfunction

    function automatic int model_vec();
        logic [5:0] r;
        logic       b, dn;
        r  = m_res[5:0];
        b  = (m_cnt >= 0 && m_cnt < 4);
        dn = (m_cnt == 4);
        return {b, dn, r, m_res % 32 == 0 ? 5'd0 : 5'(m_res % 32), 4'(m_res % 16), 3'(m_res % 8),
                m_res > 31, m_res > 15, m_res > 7};
    endfunction

    // One clock: drive inputs, let the edge happen, step the model, compare at the falling edge.
    task automatic tick(input logic st, input logic [3:0] a, b, input logic [2:0] c, d);
        start = st; A = a; B = b; C = c; D = d;
        @(posedge clk);
        model_step(st, a, b, c, d);
        @(negedge clk);
        chk("model", dut_vec(), model_vec());
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic [2:0] c, d;
        int         s6;
        logic       o5, o4, o3;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int done_cnt;
        vecs[0] = '{a:4'd5,  b:4'd3,  c:3'd7, d:3'd2, s6:17, o5:1'b0, o4:1'b1, o3:1'b1};
        vecs[1] = '{a:4'd15, b:4'd15, c:3'd7, d:3'd7, s6:44, o5:1'b1, o4:1'b1, o3:1'b1};
        vecs[2] = '{a:4'd0,  b:4'd0,  c:3'd0, d:3'd0, s6:0,  o5:1'b0, o4:1'b0, o3:1'b0};
        vecs[3] = '{a:4'd8,  b:4'd7,  c:3'd0, d:3'd0, s6:15, o5:1'b0, o4:1'b0, o3:1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_vec", dut_vec(), 0);
        rst_n = 1'b1;
        model_reset();
        tick(1'b0, 0, 0, 0, 0);

        // Spec vectors: busy for 4 cycles, then one done cycle with the expected result
        for (int v = 0; v < 4; v++) begin
            tick(1'b1, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
            chk("vec_busy0", busy, 1);
            for (int i = 0; i < 3; i++) begin
                tick(1'b0, 0, 0, 0, 0);
                chk("vec_busy", {busy, done}, 2'b10);
            end
            tick(1'b0, 0, 0, 0, 0);
            chk("vec_done", {busy, done}, 2'b01);
            chk("vec_s6", S6, vecs[v].s6);
            chk("vec_trunc", {S5, S4, S3}, {5'(vecs[v].s6), 4'(vecs[v].s6), 3'(vecs[v].s6)});
            chk("vec_ovf", {ovf5, ovf4, ovf3}, {vecs[v].o5, vecs[v].o4, vecs[v].o3});
            tick(1'b0, 0, 0, 0, 0);
            chk("vec_hold", {done, S6}, {1'b0, 6'(vecs[v].s6)});
            $display("vec %0d: A=%0d B=%0d C=%0d D=%0d -> S6=%0d", v, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d, S6);
        end

        // start and operand change during SUM are ignored
        tick(1'b1, 1, 1, 1, 1);
        tick(1'b0, 1, 1, 1, 1);
        tick(1'b1, 9, 1, 1, 1);
        tick(1'b0, 9, 1, 1, 1);
        tick(1'b0, 9, 1, 1, 1);
        chk("ign_done", {done, S6}, {1'b1, 6'd4});
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 9, 1, 1, 1);
            done_cnt += done;
        end
        chk("ign_no_second_done", done_cnt, 0);
        $display("ignored start: S6=%0d extra_done=%0d", S6, done_cnt);

        // start held high: results every 5 cycles, busy low only in done cycles
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, 2, 2, 2, 2);
            chk("held_done", done, (i % 5) == 4);
            chk("held_busy", busy, (i % 5) != 4);
            if ((i % 5) == 4) chk("held_s6", S6, 8);
        end
        tick(1'b0, 0, 0, 0, 0);
        tick(1'b0, 0, 0, 0, 0);
        $display("held start: 3 results S6=%0d", S6);

        // Asynchronous reset in the middle of an A=15 run
        tick(1'b1, 15, 1, 1, 1);
        tick(1'b0, 0, 0, 0, 0);
        tick(1'b0, 0, 0, 0, 0);
        chk("rst_pre_busy", busy, 1);
        chk("rst_pre_s6", S6, 8);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_vec", dut_vec(), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_vec", dut_vec(), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 15, 15, 7, 7);
            chk("rst_idle", {busy, done, S6}, 0);
        end
        $display("mid-run reset: outputs cleared, block idle");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom), 3'($urandom), 3'($urandom));
            if (done) $display("rand completion: S6=%0d model=%0d", S6, m_res);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soma_seq_ctrl.md
# soma_seq_ctrl

Sequential controller for the four-operand adder datapath. It captures operands A, B (4-bit) and C, D (3-bit) on a start request and sums them through one shared 6-bit adder, one operand per cycle. It then publishes the full 6-bit sum, its 5/4/3-bit truncations and per-width overflow flags with a done pulse. It replaces the parallel four-input adder wherever area is tighter than latency, and it is the block that lab-board top levels drive from push-button/switch logic.

## Interface
Parameters:
- none. Widths are fixed by the shared package.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- A  in  4  operand 0, unsigned.
- B  in  4  operand 1, unsigned.
- C  in  3  operand 2, unsigned.
- D  in  3  operand 3, unsigned.
- busy  out  1  high while in SUM.
- done  out  1  one-cycle pulse, high in DONE.
- S6  out  6  full sum, registered.
- S5  out  5  S6[4:0].
- S4  out  4  S6[3:0].
- S3  out  3  S6[2:0].
- ovf5, ovf4, ovf3  out  1 each  high when the true sum exceeds 31 / 15 / 7.

## Operation
- FSM states: IDLE, SUM, DONE.
- IDLE: if start=1, register A,B,C,D (C,D zero-extended to 6 bits), clear acc, clear step counter (2-bit), go to SUM. Otherwise stay.
- SUM: on each edge, acc <= acc + op[step], and step increments. Order is A, B, C, D. On the edge with step=3, load the result registers (S6, overflow flags) from the final sum and go to DONE.
- DONE: done=1 for exactly one cycle. If start=1, re-capture operands and go to SUM (back-to-back). Otherwise go to IDLE.
- Arithmetic: unsigned and 6-bit throughout. Maximum is 15+15+7+7=44, so S6 never wraps and there is no ovf6.
- ovfN = (S6 >> N) != 0. S5/S4/S3 are pure truncations of S6.
- Operands are sampled only at capture. Changes on A..D during SUM are ignored.
- start during SUM is ignored, with no queueing.
- Result outputs hold their last completed value until the next completion. A new start does not clear them.

## Timing
- Reset (async assert, any state): state=IDLE, acc=0, step=0, busy=0, done=0, S6=0, all ovf=0. Outputs go to these values immediately on assertion.
- Reset mid-operation: the computation is abandoned and results read 0. After release the block waits in IDLE for a new start.
- Reset deassertion is treated as synchronous-release by the top level; the block requires no extra sync.
- Latency: start is captured at edge k. Adds happen at edges k+1..k+4. busy=1 between edge k and edge k+4. done=1 and new results are valid between edge k+4 and edge k+5.
- Throughput: one result per 5 cycles with start held or re-pulsed in DONE. Otherwise one result per 5 cycles plus idle time.
- busy and done are never high simultaneously.

## Structure
- Package soma_pkg holds:
  - state encoding localparams: IDLE=2'd0, SUM=2'd1, DONE=2'd2, with 2'd3 decoding to IDLE;
  - width constants: W_AB=4, W_CD=3, W_ACC=6.
- One sub-module, somador_6b: a combinational 6-bit unsigned adder (a, b -> s, carry out unused). It is the single shared adder instance; the operand mux and acc register stay in the controller.

## Test plan
- Reset, then A=5, B=3, C=7, D=2, start pulse.
  - Required response: busy for 4 cycles, then done for 1 cycle, with S6=010001 (17), S5=10001, S4=0001, S3=001, ovf5=0, ovf4=1, ovf3=1.
- A=15, B=15, C=7, D=7.
  - Required response: S6=101100 (44), S5=01100, ovf5=1, ovf4=1, ovf3=1.
- All operands 0.
  - Required response: S6=0 and all ovf=0, with done still pulsed once at cycle k+4.
- Start with A=1, B=1, C=1, D=1. Change A to 9 and pulse start again during SUM.
  - Required response: a single completion, S6=4, and no second done.
- Start held high continuously with operands 2, 2, 2, 2.
  - Required response: done at k+4, k+9, k+14, each with S6=8, and busy low only in DONE cycles.
- Assert rst_n=0 at step=2 of an A=15 run.
  - Required response: busy, done, S6 and ovf go to 0 immediately. After release the block stays idle until the next start.
